// File: rtl/prefix_adder_pipe_if.sv
// Stream interface for prefix_adder_pipe.
//
// Carries the operand beat (in_*) and the result beat (out_*), each with its
// own valid/ready pair. The clock and reset are not part of this bundle.
//
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : adder side (drives in_ready and the result)
//
// Signals
//   in_valid  operand beat present            in_ready  adder accepts beat
//   in_a      operand A [WIDTH]               in_b      operand B [WIDTH]
//   in_cin    carry-in (ignored on subtract)  in_sub    1: A - B, 0: A + B + cin
//   out_valid result beat present             out_ready consumer accepts result
//   out_sum   result [WIDTH]                  out_cout  carry-out / not-borrow
//   out_ovf   signed two's-complement overflow
interface prefix_adder_pipe_if #(
    parameter int unsigned WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cin,
        output in_sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cout,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cin,
        input  in_sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cout,
        output out_ovf
    );

endinterface

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone parallel-prefix adder/subtractor.
//
// Built from the group generate/propagate dot operator
//   G = Gh | (Ph & Gl),  P = Ph & Pl
// applied over log2(WIDTH) prefix levels. Every stage boundary is a register:
// one pre-processing stage, L prefix levels and one output stage, so a beat
// accepted on a clock edge shows up on out_valid L+1 edges later.
//
// Flow control is a single global stall: when the output holds an unaccepted
// result every register freezes; otherwise the whole chain (bubbles included)
// shifts by one stage.
//
// Ports
//   clk   rising-edge clock
//   rst   synchronous active-high reset; clears valid bits and output regs
//   bus   prefix_adder_pipe_if.slave: operand stream in, result stream out
module prefix_adder_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    prefix_adder_pipe_if.slave  bus
);

    localparam int unsigned L = $clog2(WIDTH);

    // Prefix positions: index 0 is the carry-in folded in as bit -1, index j
    // is operand bit j-1. Bit W-1 never needs a group term of its own: its
    // carry-out is rebuilt in the output stage from its own g/p and the
    // carry into it, so WIDTH positions and exactly L levels suffice.

    logic             stall;
    logic             advance;

    logic [WIDTH-1:0] b_eff;
    logic             c0;

    logic [WIDTH-1:0] g_d    [0:L];
    logic [WIDTH-1:0] g_q    [0:L];
    // Group propagate is dead after the last level, so it is never stored there.
    logic [WIDTH-1:0] p_d    [0:L-1];
    logic [WIDTH-1:0] p_q    [0:L-1];
    // Half-sum a ^ b' rides along untouched for the final xor.
    logic [WIDTH-1:0] h_d    [0:L];
    logic [WIDTH-1:0] h_q    [0:L];
    // Top-bit generate and sign of A, needed for cout and overflow.
    logic [L:0]       gtop_d;
    logic [L:0]       gtop_q;
    logic [L:0]       amsb_d;
    logic [L:0]       amsb_q;
    logic [L:0]       valid_q;

    logic [WIDTH-1:0] sum_nx;
    logic             cout_nx;
    logic             ovf_nx;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_sum_q;
    logic             out_cout_q;
    logic             out_ovf_q;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    // Only registered out_valid and the out_ready input feed in_ready.
    assign stall        = out_valid_q & ~bus.out_ready;
    assign advance      = ~stall;
    assign bus.in_ready = ~stall;

    // ------------------------------------------------------------------
    // Next-state: pre-processing and prefix levels
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < int'(L); k++) begin
            p_d[k] = '0;
        end

        b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
        c0    = bus.in_sub | bus.in_cin;

        g_d[0]    = {bus.in_a[WIDTH-2:0] & b_eff[WIDTH-2:0], c0};
        p_d[0]    = {bus.in_a[WIDTH-2:0] ^ b_eff[WIDTH-2:0], 1'b0};
        h_d[0]    = bus.in_a ^ b_eff;
        gtop_d[0] = bus.in_a[WIDTH-1] & b_eff[WIDTH-1];
        amsb_d[0] = bus.in_a[WIDTH-1];

        // Level k combines position j with j - 2^(k-1); lower positions pass.
        for (int k = 1; k <= int'(L); k++) begin
            g_d[k] = g_q[k-1];
            for (int j = (1 << (k - 1)); j < int'(WIDTH); j++) begin
                g_d[k][j] = g_q[k-1][j] | (p_q[k-1][j] & g_q[k-1][j - (1 << (k - 1))]);
            end
            if (k < int'(L)) begin
                p_d[k] = p_q[k-1];
                for (int j = (1 << (k - 1)); j < int'(WIDTH); j++) begin
                    p_d[k][j] = p_q[k-1][j] & p_q[k-1][j - (1 << (k - 1))];
                end
            end
            h_d[k]    = h_q[k-1];
            gtop_d[k] = gtop_q[k-1];
            amsb_d[k] = amsb_q[k-1];
        end
    end

    // ------------------------------------------------------------------
    // Output stage logic
    // ------------------------------------------------------------------
    // After L levels, g_q[L][j] is the carry into operand bit j.
    always_comb begin
        sum_nx  = h_q[L] ^ g_q[L];
        cout_nx = gtop_q[L] | (h_q[L][WIDTH-1] & g_q[L][WIDTH-1]);
        // Operand signs agree (half-sum msb clear) but the result sign differs.
        ovf_nx  = ~h_q[L][WIDTH-1] & (sum_nx[WIDTH-1] ^ amsb_q[L]);
    end

    // ------------------------------------------------------------------
    // Datapath registers (no reset; qualified by the valid chain)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (advance) begin
            for (int k = 0; k <= int'(L); k++) begin
                g_q[k] <= g_d[k];
                h_q[k] <= h_d[k];
            end
            for (int k = 0; k < int'(L); k++) begin
                p_q[k] <= p_d[k];
            end
            gtop_q <= gtop_d;
            amsb_q <= amsb_d;
        end
    end

    // ------------------------------------------------------------------
    // Valid chain
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q <= {valid_q[L-1:0], bus.in_valid};
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= valid_q[L];
            // Bubbles leave the last result in place to avoid needless toggling.
            if (valid_q[L]) begin
                out_sum_q  <= sum_nx;
                out_cout_q <= cout_nx;
                out_ovf_q  <= ovf_nx;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
    assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe (WIDTH = 16).
// Expected results come from plain integer arithmetic on A + b' + c0; a queue
// of expected beats is checked in order every cycle the output transfers.
module tb_prefix_adder_pipe;

    localparam int W = 16;
    localparam int L = $clog2(W);

    typedef struct packed {
        logic         ovf;
        logic         cout;
        logic [W-1:0] sum;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prefix_adder_pipe_if #(.WIDTH(W)) bus ();

    prefix_adder_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    res_t q[$];
    res_t held;
    res_t snap_res;
    logic prev_stall = 1'b0;
    logic snap_valid;
    logic snap_ready;
    logic accepted;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    // Reference: full-precision unsigned sum and signed range test.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [W-1:0] bp;
        longint      c0;
        longint      u;
        longint      s;
        bp     = sub ? ~b : b;
        c0     = sub ? 64'sd1 : longint'({63'd0, cin});
        u      = longint'({48'd0, a}) + longint'({48'd0, bp}) + c0;
        s      = longint'($signed(a)) + longint'($signed(bp)) + c0;
        r.sum  = u[W-1:0];
        r.cout = u[W];
        r.ovf  = (s > 64'sd32767) || (s < -64'sd32768);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return W'($urandom());
        endcase
    endfunction

    // Per-cycle compare: runs mid-cycle when inputs and outputs are stable.
    task automatic monitor();
        logic stall;
        res_t cur;
        res_t exp;
        stall      = bus.out_valid && !bus.out_ready;
        cur        = res_t'({bus.out_ovf, bus.out_cout, bus.out_sum});
        snap_valid = bus.out_valid;
        snap_ready = bus.in_ready;
        snap_res   = cur;
        chk("in_ready_rule", 64'(bus.in_ready), 64'(!stall));
        if (prev_stall) begin
            chk("stall_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_hold_data", 64'(cur), 64'(held));
        end
        prev_stall = stall && !rst;
        held       = cur;
        accepted   = 1'b0;
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got 0x%0h want none", cur);
                end else begin
                    exp = q.pop_front();
                    chk("stream_result", 64'(cur), 64'(exp));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));
                accepted = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic set_random();
        bus.in_a   = pick();
        bus.in_b   = pick();
        bus.in_cin = 1'($urandom_range(0, 1));
        bus.in_sub = 1'($urandom_range(0, 1));
    endtask

    // Single beat into an empty pipe; checks model, latency, value, uniqueness.
    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input res_t lit);
        int n;
        chk({name, "_model"}, 64'(model(a, b, cin, sub)), 64'(lit));
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_cin    = cin;
        bus.in_sub    = sub;
        bus.out_ready = 1'b1;
        tick();
        chk({name, "_accept"}, 64'(accepted), 64'(1));
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!snap_valid && n < 20);
        chk({name, "_latency"}, 64'(n), 64'(L + 2));
        chk({name, "_value"}, 64'(snap_res), 64'(lit));
        tick();
        chk({name, "_single"}, 64'(snap_valid), 64'(0));
    endtask

    task automatic drain();
        int n;
        bus.in_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 1000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
        end
        bus.out_ready = 1'b1;
        repeat (L + 3) tick();
    endtask

    initial begin
        int got;
        int n;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_out_valid", 64'(snap_valid), 64'(0));
        chk("reset_out_data", 64'(snap_res), 64'(0));
        chk("reset_in_ready", 64'(snap_ready), 64'(1));

        directed("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, res_t'{1'b0, 1'b0, 16'h5555});
        directed("carry_full", 16'hFFFF, 16'h0000, 1'b1, 1'b0, res_t'{1'b0, 1'b1, 16'h0000});
        directed("sub_cin_ig", 16'hFFFF, 16'h0000, 1'b1, 1'b1, res_t'{1'b0, 1'b1, 16'hFFFF});
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, res_t'{1'b0, 1'b0, 16'hFFFE});
        directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, res_t'{1'b1, 1'b0, 16'h8000});
        directed("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, res_t'{1'b1, 1'b1, 16'h7FFF});

        // 20 back-to-back beats under random backpressure.
        got = 0;
        n   = 0;
        bus.in_valid = 1'b1;
        set_random();
        while (got < 20 && n < 500) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (accepted) begin
                got++;
                set_random();
            end
        end
        chk("stream_accepted", 64'(got), 64'(20));
        drain();

        // Reset with three beats in flight; a beat offered during reset is dropped.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        repeat (3) begin
            set_random();
            tick();
        end
        set_random();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_random();
        tick();
        chk("post_reset_valid", 64'(snap_valid), 64'(0));
        chk("post_reset_ready", 64'(snap_ready), 64'(1));
        chk("post_reset_accept", 64'(accepted), 64'(1));
        bus.in_valid = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!snap_valid && n < 20);
        chk("post_reset_latency", 64'(n), 64'(L + 2));
        drain();

        // Random regression with bubbles and backpressure.
        for (int i = 0; i < 3000; i++) begin
            bus.in_valid  = ($urandom_range(0, 9) < 8);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            set_random();
            tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
